// File: rtl/od_line_rx_if.sv
// ============================================================================
// Module      : od_line_rx_if
// Description : Bus-side and consumer-side signals of the open-drain line
//               receiver. The master modport is the receiver; the slave
//               modport is the environment (line driver and byte consumer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface od_line_rx_if;
   logic       line_in;     // resolved wired-AND bus level
   logic [7:0] rx_data;     // received byte
   logic       rx_valid;    // byte available
   logic       rx_ready;    // consumer accepts byte
   logic       bus_reset;   // one-cycle bus-reset indication
   logic       overflow;    // sticky dropped-byte flag

   modport master (
      input  line_in,
      input  rx_ready,
      output rx_data,
      output rx_valid,
      output bus_reset,
      output overflow
   );

   modport slave (
      output line_in,
      output rx_ready,
      input  rx_data,
      input  rx_valid,
      input  bus_reset,
      input  overflow
   );
endinterface

`default_nettype wire

// File: rtl/od_line_rx.sv
// ============================================================================
// Module      : od_line_rx
// Description : Open-drain single-wire receiver. Measures each low pulse on
//               the synchronized line, classifies it as glitch / bit 1 /
//               bit 0 / bus reset, assembles bytes LSB-first and hands them
//               out on a valid/ready port with a sticky overflow flag.
// Config      : OD_RX_GLITCH_FILTER_EN - when defined, pulses shorter than
//               LOW_MIN are discarded; otherwise every short pulse is a 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module od_line_rx #(
   parameter int LOW_MIN   = 2,
   parameter int ONE_MAX   = 8,
   parameter int RESET_MIN = 40,
   parameter int CW        = 8
) (
   input  wire logic     clk,
   input  wire logic     rst,
   od_line_rx_if.master  bus
);

`ifdef OD_RX_GLITCH_FILTER_EN
   localparam int MIN_LEN = LOW_MIN;
`else
   // Pulse lengths seen by the classifier are always at least 1, so this
   // threshold admits every pulse.
   localparam int MIN_LEN = (LOW_MIN < 1) ? LOW_MIN : 1;
`endif

   localparam logic [CW-1:0] MIN_CNT = CW'(MIN_LEN);
   localparam logic [CW-1:0] ONE_CNT = CW'(ONE_MAX);
   localparam logic [CW-1:0] RST_CNT = CW'(RESET_MIN);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOW      = 2'd1,
      RST_WAIT = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic          sync_meta;
   logic          line_s;
   logic [CW-1:0] low_cnt;
   logic [7:0]    shift_reg;
   logic [7:0]    assembled;
   logic [2:0]    bit_cnt;
   logic [7:0]    byte_buf;
   logic          byte_done;
   logic          bit_en;
   logic          bit_val;
   logic          reset_det;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          reset_pulse;
   logic          ovf;

   // Two-flop synchronizer; idles high like the released bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b1;
         line_s    <= 1'b1;
      end else begin
         sync_meta <= bus.line_in;
         line_s    <= sync_meta;
      end
   end

   // Low-length counter: restarts at 1 on a falling edge, saturates at RESET_MIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         low_cnt <= '0;
      end else if (!line_s) begin
         if (state == IDLE)
            low_cnt <= CW'(1);
         else if (low_cnt != RST_CNT)
            low_cnt <= low_cnt + CW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next state and pulse classification at the end of a low pulse.
   always_comb begin
      next_state = state;
      bit_en     = 1'b0;
      bit_val    = 1'b0;
      reset_det  = 1'b0;
      case (state)
         IDLE: begin
            if (!line_s)
               next_state = LOW;
         end
         LOW: begin
            if (low_cnt == RST_CNT) begin
               reset_det  = 1'b1;
               next_state = line_s ? IDLE : RST_WAIT;
            end else if (line_s) begin
               next_state = IDLE;
               if (low_cnt <= ONE_CNT) begin
                  bit_val = 1'b1;
                  bit_en  = (low_cnt >= MIN_CNT);
               end else begin
                  bit_en  = 1'b1;
               end
            end
         end
         RST_WAIT: begin
            if (line_s)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Partial byte with the current bit merged in at its position.
   always_comb begin
      assembled          = shift_reg;
      assembled[bit_cnt] = bit_val;
   end

   // Byte assembly; a bus reset discards the partial byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg   <= '0;
         bit_cnt     <= '0;
         byte_buf    <= '0;
         byte_done   <= 1'b0;
         reset_pulse <= 1'b0;
      end else begin
         byte_done   <= 1'b0;
         reset_pulse <= reset_det;
         if (reset_det) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (bit_en) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               shift_reg <= '0;
               byte_buf  <= assembled;
               byte_done <= 1'b1;
            end else begin
               shift_reg <= assembled;
            end
         end
      end
   end

   // Output holding register with valid/ready handshake and drop detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (byte_done) begin
         if (!out_valid || bus.rx_ready) begin
            out_data  <= byte_buf;
            out_valid <= 1'b1;
         end else begin
            ovf <= 1'b1;
         end
      end else if (out_valid && bus.rx_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.rx_data   = out_data;
   assign bus.rx_valid  = out_valid;
   assign bus.bus_reset = reset_pulse;
   assign bus.overflow  = ovf;

endmodule

`default_nettype wire

// File: tb/tb_od_line_rx.sv
// ============================================================================
// Module      : tb_od_line_rx
// Description : Self-checking bench for od_line_rx: directed byte table plus
//               hand-written latency, glitch, bus-reset, backpressure and
//               reset sequences. Glitch expectation follows
//               OD_RX_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_od_line_rx;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] exp_data;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   od_line_rx_if bus ();

   od_line_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Line held low for exactly len sampling edges, then high for gap edges.
   task automatic send_pulse(input int len, input int gap);
      bus.line_in = 1'b0;
      repeat (len) tick();
      bus.line_in = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         send_pulse(b[i] ? 4 : 15, 3);
   endtask

   task automatic wait_valid(input string name, input int max);
      int n;
      n = 0;
      while (!bus.rx_valid && n < max) begin
         tick();
         n++;
      end
      chk(name, bus.rx_valid, 1);
   endtask

   task automatic accept(input string name);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      chk(name, bus.rx_valid, 0);
   endtask

   vec_t vecs [6];
   int   pulses;
   int   pulse_at;
   logic [7:0] glitch_exp;

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{tx: 8'h00, exp_data: 8'h00};
      vecs[1] = '{tx: 8'hFF, exp_data: 8'hFF};
      vecs[2] = '{tx: 8'h5A, exp_data: 8'h5A};
      vecs[3] = '{tx: 8'h01, exp_data: 8'h01};
      vecs[4] = '{tx: 8'h80, exp_data: 8'h80};
      vecs[5] = '{tx: 8'hC3, exp_data: 8'hC3};
`ifdef OD_RX_GLITCH_FILTER_EN
      glitch_exp = 8'h3C;
`else
      glitch_exp = 8'h79;
`endif

      // Reset state
      rst          = 1'b1;
      bus.line_in  = 1'b1;
      bus.rx_ready = 1'b0;
      repeat (3) tick();
      chk("reset rx_data",   bus.rx_data,   0);
      chk("reset rx_valid",  bus.rx_valid,  0);
      chk("reset bus_reset", bus.bus_reset, 0);
      chk("reset overflow",  bus.overflow,  0);
      rst = 1'b0;
      repeat (2) tick();

      // 0xA5 with exact latency: valid rises 3 edges after last release
      send_byte(8'hA5);
      chk("a5 valid not early", bus.rx_valid, 0);
      tick();
      chk("a5 valid on time", bus.rx_valid, 1);
      chk("a5 data", bus.rx_data, 8'hA5);
      accept("a5 accept");

      // Byte table
      for (int i = 0; i < 6; i++) begin
         send_byte(vecs[i].tx);
         wait_valid($sformatf("vec%0d valid", i), 5);
         chk($sformatf("vec%0d data", i), bus.rx_data, vecs[i].exp_data);
         chk($sformatf("vec%0d bus_reset", i), bus.bus_reset, 0);
         accept($sformatf("vec%0d accept", i));
      end

      // Glitch ahead of 0x3C
      send_pulse(1, 3);
      send_byte(8'h3C);
      wait_valid("glitch valid", 5);
      chk("glitch data", bus.rx_data, glitch_exp);
      accept("glitch accept");
      send_pulse(50, 3);   // flush any leftover partial bit

      // Bus reset mid-byte
      send_pulse(4, 3);
      send_pulse(15, 3);
      send_pulse(4, 3);
      pulses   = 0;
      pulse_at = -1;
      bus.line_in = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.bus_reset) begin
            pulses++;
            pulse_at = k;
         end
      end
      bus.line_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.bus_reset) pulses++;
      end
      chk("busrst pulse count", pulses, 1);
      chk("busrst pulse edge", pulse_at, 42);
      chk("busrst no byte", bus.rx_valid, 0);
      send_byte(8'h81);
      wait_valid("busrst next valid", 5);
      chk("busrst next data", bus.rx_data, 8'h81);
      chk("busrst overflow", bus.overflow, 0);
      accept("busrst accept");

      // Accept on the exact completion cycle of a new byte
      send_byte(8'h66);
      wait_valid("simul 66 valid", 5);
      send_byte(8'h77);
      chk("simul hold 66", bus.rx_data, 8'h66);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      chk("simul data", bus.rx_data, 8'h77);
      chk("simul valid", bus.rx_valid, 1);
      chk("simul overflow", bus.overflow, 0);
      accept("simul accept");

      // Backpressure: second byte dropped
      send_byte(8'h11);
      wait_valid("bp 11 valid", 5);
      send_byte(8'h22);
      repeat (2) tick();
      chk("bp data held", bus.rx_data, 8'h11);
      chk("bp valid", bus.rx_valid, 1);
      chk("bp overflow", bus.overflow, 1);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      chk("bp valid falls", bus.rx_valid, 0);
      chk("bp overflow sticky", bus.overflow, 1);

      // Reset after 5 bits
      for (int i = 0; i < 5; i++) send_pulse(4, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst rx_data",   bus.rx_data,   0);
      chk("midrst rx_valid",  bus.rx_valid,  0);
      chk("midrst bus_reset", bus.bus_reset, 0);
      chk("midrst overflow",  bus.overflow,  0);
      send_byte(8'hF0);
      wait_valid("midrst next valid", 5);
      chk("midrst next data", bus.rx_data, 8'hF0);
      chk("midrst next overflow", bus.overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/od_line_rx.md
# od_line_rx

Open-drain single-wire line receiver that decodes pulse-width-encoded bits from a shared, wired-AND bus. The bus is driven by several tristate drivers that only ever pull low and is otherwise pulled up. The block reads the resolved line, classifies each low pulse as glitch, data 1, data 0 or bus reset, and assembles bytes LSB-first. Bytes are delivered on a valid/ready port to the local consumer. It is the listening end of the pull-low drivers that share the bus.

## Interface
- LOW_MIN, default 2: minimum low-pulse length in cycles for a pulse to count as a bit; shorter pulses are glitches.
- ONE_MAX, default 8: low length ≤ ONE_MAX decodes as bit 1; longer decodes as bit 0.
- RESET_MIN, default 40: low length ≥ RESET_MIN is a bus reset. Legal settings satisfy LOW_MIN ≤ ONE_MAX < RESET_MIN < 2^CW.
- CW, default 8: width of the low-length counter.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- line_in  in  1  resolved bus level, asynchronous to clk. 0 means some driver is pulling low; 1 means released (z reads as 1 through the pull-up).
- rx_data  out  8  received byte; stable while rx_valid = 1.
- rx_valid  out  1  byte available.
- rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready.
- bus_reset  out  1  one-cycle pulse when a bus-reset pulse is detected.
- overflow  out  1  sticky; set when a completed byte is dropped. Cleared only by rst.

## Operation
- Input stage: 2-flop synchronizer on line_in, reset value 1. The synchronized value `s` drives all logic below.
- Low-length counter `cnt`:
  - Loaded with 1 on the first cycle `s` = 0 after `s` = 1.
  - Increments each further cycle `s` = 0.
  - Saturates at RESET_MIN.
- FSM states:
  - IDLE (`s` = 1) → LOW when `s` = 0.
  - LOW → RST_WAIT when `cnt` reaches RESET_MIN. bus_reset pulses on that cycle; the shift register and bit counter clear.
  - LOW → IDLE when `s` = 1. The pulse length L = `cnt` is classified:
    - L < LOW_MIN: glitch, ignored.
    - LOW_MIN ≤ L ≤ ONE_MAX: bit 1.
    - ONE_MAX < L < RESET_MIN: bit 0.
  - RST_WAIT → IDLE when `s` = 1. No bit is produced.
- Byte assembly: each bit shifts in at bit[bitcnt], LSB-first, where bitcnt runs 0..7. The 8th bit completes the byte and bitcnt wraps to 0.
- Output register, on byte completion:
  - If rx_valid = 0, or rx_valid & rx_ready in the same cycle: load rx_data, rx_valid = 1.
  - Otherwise: drop the new byte, keep the old one, set overflow.
- Handshake: rx_valid falls the cycle after rx_valid & rx_ready unless a new byte loads in that same cycle. rx_data does not change while rx_valid = 1 and rx_ready = 0.
- A bus reset does not affect rx_valid, rx_data or overflow. It discards only the partial byte.
- Reset values: rx_data = 0, rx_valid = 0, bus_reset = 0, overflow = 0, state = IDLE, bitcnt = 0, cnt = 0, synchronizer = 1.
- rst asserted mid-pulse or mid-byte discards everything. After release, a line still low is seen as a fresh falling edge once the synchronizer propagates.

## Timing
- Synchronizer latency: 2 cycles from line_in to `s`.
- Bit decision is made on the edge where `s` first returns to 1. rx_valid rises on the following edge, i.e. 3 edges after the edge that first samples line_in = 1 for the 8th bit.
- bus_reset is asserted exactly RESET_MIN + 2 edges after the edge that first samples line_in = 0. It lasts exactly 1 cycle.
- Throughput: bits need no minimum high gap beyond 1 cycle of `s` = 1.

## Configuration
- OD_RX_GLITCH_FILTER_EN defined: pulses with L < LOW_MIN are discarded as described.
- OD_RX_GLITCH_FILTER_EN undefined: LOW_MIN is ignored. Any low pulse with L ≥ 1 and L ≤ ONE_MAX decodes as bit 1.

## Test plan
Defaults apply; the filter is enabled unless stated.
- Bit values: send 8 pulses encoding 0xA5 LSB-first (1 = 4-cycle low, 0 = 15-cycle low, 3-cycle high gaps) → rx_data = 0xA5, rx_valid = 1, 3 edges after the last release.
- Glitch filter: 1-cycle low glitch inserted between bits of 0x3C → rx_data = 0x3C. Without OD_RX_GLITCH_FILTER_EN, the glitch counts as a bit 1 → rx_data = 0x79.
- Bus reset mid-byte: 3 bits, then a 50-cycle low, then 0x81 → bus_reset pulses once at cycle 42 of the low, no byte is emitted for the partial bits, next byte rx_data = 0x81.
- Backpressure: rx_ready = 0 while 0x11 and then 0x22 are sent → rx_data stays 0x11 and overflow = 1. Asserting rx_ready → rx_valid falls next cycle, overflow stays 1.
- Simultaneous accept and complete: rx_ready pulses on the exact completion cycle of 0x77 while 0x66 is pending → rx_data = 0x77, rx_valid stays 1, overflow = 0.
- Reset mid-operation: rst for 1 cycle after 5 bits, then 0xF0 is sent → all outputs return to reset values, next byte = 0xF0.
